skid_stage: RTL and testbench
=============================

// Module: skid_stage
// PURPOSE
//  Elastic pipeline stage with valid/ready handshake and a one-entry skid register.
//  Sits directly upstream of the datapath operand-select mux2 instances and feeds their D0/D1 inputs.
//  Cuts the ready path combinationally: in_ready is a register output.
//  Carries full throughput (1 word/clk) under continuous flow.
//  Supports a synchronous flush for branch/jump squash.
// PARAMETERS
//  n  32  data word width in bits (matches mux2 n)
// PORTS
//  clk        in   1  single clock, rising edge
//  reset_n    in   1  asynchronous, active-low reset
//  flush      in   1  synchronous squash of all held words
//  in_valid   in   1  upstream word present
//  in_ready   out  1  stage can accept a word this cycle (registered)
//  in_data    in   n  upstream word
//  out_valid  out  1  out_data holds a valid word
//  out_ready  in   1  downstream accepts out_data this cycle
//  out_data   out  n  word to downstream mux2 input
// BEHAVIOUR
//  Reset (reset_n=0, async): state=EMPTY, out_valid=0, in_ready=1, out_data=0, skid=0.
//  Transfer in  = in_valid & in_ready; transfer out = out_valid & out_ready.
//  States (enum from package):
//   EMPTY: out_valid=0, in_ready=1.
//    - xfer in -> main<=in_data, go BUSY.
//   BUSY: out_valid=1, in_ready=1.
//    - in & out -> main<=in_data, stay BUSY.
//    - in only  -> skid<=in_data, go FULL.
//    - out only -> go EMPTY.
//    - neither  -> hold.
//   FULL: out_valid=1, in_ready=0.
//    - out -> main<=skid, go BUSY.
//    - else -> hold.
//  Latency: a word accepted in cycle t is visible on out_data in cycle t+1.
//  Order is strictly FIFO; no word is dropped or duplicated.
//  out_data must stay stable while out_valid=1 and out_ready=0.
//  flush=1 (highest priority after reset): next state EMPTY.
//   - Any concurrent in/out transfer is discarded; data regs keep stale values.
//  in_data is ignored when in_valid=0 or in_ready=0.
//  out_ready has no effect when out_valid=0.
//  Width: no arithmetic; all data paths are exactly n bits.
//  reset_n asserted mid-transfer: immediate EMPTY; the word in flight is lost by design.
// STRUCTURE
//  Package pipe_pkg:
//   - typedef enum logic [1:0] {EMPTY=2'b00, BUSY=2'b01, FULL=2'b10} skid_state_t.
//   - Illegal encoding 2'b11 recovers to EMPTY.
//  Sub-module: one mux2 #(n) instance selects the main-register load source.
//   - D0=in_data, D1=skid, S=(state==FULL).
//  All other logic (state register, main/skid registers, next-state logic) is local to this module.
// TESTING
//  1 Reset: hold reset_n=0, toggle in_valid -> out_valid=0, in_ready=1, out_data=0.
//  2 Stream: out_ready=1; push 0x11,0x22,0x33 on consecutive clks.
//    - out_data shows 0x11,0x22,0x33 one cycle later; in_ready stays 1.
//  3 Backpressure: out_ready=0, push 0xA1,0xA2.
//    - in_ready drops to 0 after 0xA2; out_data holds 0xA1.
//    - Raise out_ready -> 0xA1 then 0xA2 out, then EMPTY.
//  4 Simultaneous in/out in FULL: in_valid=1 with 0xB3 while out_ready=1.
//    - 0xB3 is not accepted (in_ready=0); the skid word moves to main; state BUSY.
//  5 Flush in FULL with in_valid=1.
//    - Next cycle out_valid=0, in_ready=1; no held word ever appears on out_data.
//  6 Async reset mid-stream: drop reset_n between clk edges.
//    - out_valid=0 immediately, not at the next edge.
//    - Run a random valid/ready scoreboard for 10k cycles -> zero mismatches.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline types.
//   skid_state_t : occupancy of the skid stage (EMPTY = no word held,
//                  BUSY = one word in main, FULL = main and skid both held).
//                  Encoding 2'b11 is unused and recovers to EMPTY.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    BUSY  = 2'b01,
    FULL  = 2'b10
  } skid_state_t;

endpackage

// File: rtl/mux2.sv
// Two-input word multiplexer.
//   n  : word width
//   d0 : selected when s = 0
//   d1 : selected when s = 1
//   s  : select
//   y  : selected word
module mux2 #(
  parameter int unsigned n = 32
) (
  input  logic [n-1:0] d0,
  input  logic [n-1:0] d1,
  input  logic         s,
  output logic [n-1:0] y
);

  assign y = s ? d1 : d0;

endmodule

// File: rtl/skid_stage.sv
// Elastic pipeline stage with a one-entry skid register.
// in_ready and out_valid come straight from flops, so no combinational
// path runs from out_ready back to in_ready. Full throughput under flow.
//   clk       : rising-edge clock
//   reset_n   : asynchronous active-low reset
//   flush     : synchronous squash of every held word
//   in_valid  / in_ready  / in_data  : upstream handshake and word
//   out_valid / out_ready / out_data : downstream handshake and word
module skid_stage
  import pipe_pkg::*;
#(
  parameter int unsigned n = 32
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [n-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [n-1:0] out_data
);

  skid_state_t  state_q, state_d;
  logic [n-1:0] main_q, skid_q, main_src;
  logic         in_ready_q, out_valid_q;
  logic         xfer_in, xfer_out;
  logic         load_main, load_skid;

  assign xfer_in  = in_valid & in_ready_q;
  assign xfer_out = out_valid_q & out_ready;

  // Main register loads from the skid word only when draining FULL.
  mux2 #(.n(n)) u_main_sel (
    .d0 (in_data),
    .d1 (skid_q),
    .s  (state_q == FULL),
    .y  (main_src)
  );

  always_comb begin
    state_d   = state_q;
    load_main = 1'b0;
    load_skid = 1'b0;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (xfer_in) begin
            load_main = 1'b1;
            state_d   = BUSY;
          end
        end
        BUSY: begin
          if (xfer_in && xfer_out) begin
            load_main = 1'b1;
          end else if (xfer_in) begin
            load_skid = 1'b1;
            state_d   = FULL;
          end else if (xfer_out) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (xfer_out) begin
            load_main = 1'b1;
            state_d   = BUSY;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // Handshake flags are registered from the next state so they match
  // the state register on every cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      main_q      <= '0;
      skid_q      <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= (state_d != FULL);
      out_valid_q <= (state_d != EMPTY);
      if (load_main) main_q <= main_src;
      if (load_skid) skid_q <= in_data;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = main_q;

endmodule

// File: tb/tb_skid_stage.sv
module tb_skid_stage;

  localparam int unsigned N = 32;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [N-1:0] in_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [N-1:0] out_data;

  int unsigned  n_total = 0;
  int unsigned  n_pass  = 0;

  logic [N-1:0] exp_q[$];

  always #5 clk = ~clk;

  skid_stage #(.n(N)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Monitor / scoreboard: sampled mid-cycle while inputs are stable.
  // The queue depth is the reference occupancy (0, 1 or 2 words).
  always @(negedge clk) begin
    bit exp_ready, exp_valid;
    if (!reset_n) begin
      exp_q.delete();
      chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
      chk("rst_in_ready",  {31'b0, in_ready},  32'd1);
      chk("rst_out_data",  out_data, 32'd0);
    end else begin
      exp_valid = (exp_q.size() != 0);
      exp_ready = (exp_q.size() < 2);
      chk("out_valid", {31'b0, out_valid}, {31'b0, exp_valid});
      chk("in_ready",  {31'b0, in_ready},  {31'b0, exp_ready});
      if (exp_valid) chk("out_data", out_data, exp_q[0]);
      if (flush) begin
        exp_q.delete();
      end else begin
        if (exp_valid && out_ready) void'(exp_q.pop_front());
        if (exp_ready && in_valid)  exp_q.push_back(in_data);
      end
    end
  end

  // One cycle of stimulus: inputs applied just after a rising edge.
  task automatic step(input bit v, input logic [N-1:0] d, input bit r, input bit f);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    flush     = f;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // 1: reset held, in_valid toggling
    for (int unsigned i = 0; i < 4; i++) step(i[0], 32'hDEAD0000 + i, 1'b1, 1'b0);
    reset_n = 1'b1;
    step(1'b0, '0, 1'b0, 1'b0);

    // 2: streaming
    step(1'b1, 32'h11, 1'b1, 1'b0);
    step(1'b1, 32'h22, 1'b1, 1'b0);
    step(1'b1, 32'h33, 1'b1, 1'b0);
    step(1'b0, 32'h0,  1'b1, 1'b0);
    step(1'b0, 32'h0,  1'b1, 1'b0);

    // 3: backpressure then drain
    step(1'b1, 32'hA1, 1'b0, 1'b0);
    step(1'b1, 32'hA2, 1'b0, 1'b0);
    step(1'b1, 32'hA9, 1'b0, 1'b0);
    step(1'b0, 32'h0,  1'b0, 1'b0);
    step(1'b0, 32'h0,  1'b1, 1'b0);
    step(1'b0, 32'h0,  1'b1, 1'b0);
    step(1'b0, 32'h0,  1'b1, 1'b0);

    // 4: offer while FULL and draining
    step(1'b1, 32'hB1, 1'b0, 1'b0);
    step(1'b1, 32'hB2, 1'b0, 1'b0);
    step(1'b1, 32'hB3, 1'b1, 1'b0);
    step(1'b0, 32'h0,  1'b1, 1'b0);
    step(1'b0, 32'h0,  1'b1, 1'b0);

    // 5: flush while FULL with a word offered
    step(1'b1, 32'hC1, 1'b0, 1'b0);
    step(1'b1, 32'hC2, 1'b0, 1'b0);
    step(1'b1, 32'hC3, 1'b1, 1'b1);
    step(1'b0, 32'h0,  1'b1, 1'b0);
    step(1'b0, 32'h0,  1'b1, 1'b0);

    // 6: asynchronous reset between edges
    step(1'b1, 32'hD1, 1'b0, 1'b0);
    step(1'b1, 32'hD2, 1'b0, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_out_valid", {31'b0, out_valid}, 32'd0);
    chk("async_in_ready",  {31'b0, in_ready},  32'd1);
    @(posedge clk);
    #1;
    step(1'b1, 32'hD3, 1'b1, 1'b0);
    reset_n = 1'b1;

    // Random traffic against the scoreboard
    for (int unsigned i = 0; i < 10000; i++)
      step($urandom_range(0, 1) == 1, $urandom, $urandom_range(0, 3) != 0,
           $urandom_range(0, 49) == 0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
